// File: rtl/regfile_write_arbiter.sv
// Arbitrates the single register-file write port between processor writeback
// (zero-latency pass-through) and a FIFO of I/O writes issued in idle slots.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clock,
  input  logic                         ctrl_reset,
  input  logic                         cpu_we,
  input  logic [4:0]                   cpu_waddr,
  input  logic [31:0]                  cpu_wdata,
  input  logic                         io_valid,
  output logic                         io_ready,
  input  logic [4:0]                   io_waddr,
  input  logic [31:0]                  io_wdata,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [31:0]                  rf_wdata,
  output logic                         stall_cpu,
  output logic [$clog2(DEPTH+1)-1:0]   io_pending
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(STARVE_LIMIT+1);

  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] starve_cnt;

  logic        fifo_empty;
  logic        cpu_live;
  logic        push;
  logic        pop;
  logic        denied;
  logic        starve_hit;
  logic        grant_we;
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign head_addr  = fifo_addr[head];
  assign head_data  = fifo_data[head];
  assign fifo_empty = (io_pending == '0);
  assign io_ready   = (io_pending < OCC_W'(DEPTH));
  // The processor loses its write enable for the one stall cycle so the head can issue.
  assign cpu_live   = cpu_we && (cpu_waddr != 5'd0) && !stall_cpu;
  assign push       = io_valid && io_ready;
  assign pop        = !cpu_live && !fifo_empty;
  assign denied     = cpu_live && !fifo_empty;
  assign starve_hit = denied && (starve_cnt == CNT_W'(STARVE_LIMIT - 1));

  always_comb begin
    grant_we = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (cpu_live) begin
      grant_we = 1'b1;
      rf_waddr = cpu_waddr;
      rf_wdata = cpu_wdata;
    end else if (!fifo_empty) begin
      grant_we = (head_addr != 5'd0);
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end
  end

  // Reset is asynchronous, so the write enable must be masked combinationally too.
  assign rf_we = grant_we && ctrl_reset;

  // FIFO payload carries no reset; the pointers alone define validity.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[tail] <= io_waddr;
      fifo_data[tail] <= io_wdata;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      head       <= '0;
      tail       <= '0;
      io_pending <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   io_pending <= io_pending + 1'b1;
        2'b01:   io_pending <= io_pending - 1'b1;
        default: io_pending <= io_pending;
      endcase
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      starve_cnt <= '0;
      stall_cpu  <= 1'b0;
    end else begin
      stall_cpu <= starve_hit;
      if (fifo_empty || pop || starve_hit) begin
        starve_cnt <= '0;
      end else if (denied) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter: queued I/O writes are scoreboarded
// on entry and compared against the regfile port when they issue.
module tb_regfile_write_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int OCC_W        = $clog2(DEPTH+1);

  logic             clock;
  logic             ctrl_reset;
  logic             cpu_we;
  logic [4:0]       cpu_waddr;
  logic [31:0]      cpu_wdata;
  logic             io_valid;
  logic             io_ready;
  logic [4:0]       io_waddr;
  logic [31:0]      io_wdata;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic             stall_cpu;
  logic [OCC_W-1:0] io_pending;

  int checks = 0;
  int passes = 0;
  logic [36:0] exp_q[$];
  logic [36:0] e;
  logic [31:0] shadow [32];
  bit          r0_written;

  regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .cpu_we     (cpu_we),
    .cpu_waddr  (cpu_waddr),
    .cpu_wdata  (cpu_wdata),
    .io_valid   (io_valid),
    .io_ready   (io_ready),
    .io_waddr   (io_waddr),
    .io_wdata   (io_wdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_cpu  (stall_cpu),
    .io_pending (io_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (ctrl_reset && rf_we) begin
      shadow[rf_waddr] <= rf_wdata;
      if (rf_waddr == 5'd0) r0_written <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_io(input logic v, input logic [4:0] a, input logic [31:0] d, input bit rec);
    io_valid = v;
    io_waddr = a;
    io_wdata = d;
    if (v && rec) exp_q.push_back({a, d});
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b0;
    cpu_we = 1'b1; cpu_waddr = 5'd5; cpu_wdata = 32'h0000_0055;
    drive_io(1'b0, 5'd0, 32'd0, 1'b0);
    repeat (2) tick();
    checks++;
    if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %0b want 0", rf_we);
    else passes++;
    checks++;
    if ({io_ready, io_pending, stall_cpu} !== {1'b1, OCC_W'(0), 1'b0})
      $display("FAIL reset_state: ready=%0b pending=%0d stall=%0b want 1/0/0", io_ready, io_pending, stall_cpu);
    else passes++;
    ctrl_reset = 1'b1;
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h0000_0055})
      $display("FAIL reset_release: got we=%0b addr=%0d data=%h want 1/5/55", rf_we, rf_waddr, rf_wdata);
    else passes++;
    cpu_we = 1'b0;
    tick();
  endtask

  task automatic test_idle_issue();
    cpu_we = 1'b0;
    drive_io(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1);
    #1;
    checks++;
    if (rf_we !== 1'b0) $display("FAIL idle_empty_we: got %0b want 0", rf_we);
    else passes++;
    tick();
    drive_io(1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checks++;
    if (io_pending !== OCC_W'(1)) $display("FAIL idle_pending1: got %0d want 1", io_pending);
    else passes++;
    e = exp_q.pop_front();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {(e[36:32] != 5'd0), e})
      $display("FAIL idle_issue: got we=%0b addr=%0d data=%h want addr=%0d data=%h", rf_we, rf_waddr, rf_wdata, e[36:32], e[31:0]);
    else passes++;
    tick();
    checks++;
    if ({io_pending, rf_we} !== {OCC_W'(0), 1'b0})
      $display("FAIL idle_drained: pending=%0d we=%0b want 0/0", io_pending, rf_we);
    else passes++;
  endtask

  task automatic test_starvation();
    cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h0000_3333;
    drive_io(1'b1, 5'd12, 32'hA5A5_0012, 1'b1);
    tick();
    drive_io(1'b0, 5'd0, 32'd0, 1'b0);
    for (int c = 1; c <= STARVE_LIMIT; c++) begin
      #1;
      checks++;
      if ({rf_we, rf_waddr, stall_cpu} !== {1'b1, 5'd3, 1'b0})
        $display("FAIL starve_cpu_c%0d: we=%0b addr=%0d stall=%0b want 1/3/0", c, rf_we, rf_waddr, stall_cpu);
      else passes++;
      tick();
    end
    #1;
    checks++;
    if (stall_cpu !== 1'b1) $display("FAIL starve_stall: got %0b want 1", stall_cpu);
    else passes++;
    e = exp_q.pop_front();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {(e[36:32] != 5'd0), e})
      $display("FAIL starve_issue: got we=%0b addr=%0d data=%h want addr=%0d data=%h", rf_we, rf_waddr, rf_wdata, e[36:32], e[31:0]);
    else passes++;
    tick();
    checks++;
    if ({stall_cpu, rf_we, rf_waddr, io_pending} !== {1'b0, 1'b1, 5'd3, OCC_W'(0)})
      $display("FAIL starve_resume: stall=%0b we=%0b addr=%0d pending=%0d want 0/1/3/0", stall_cpu, rf_we, rf_waddr, io_pending);
    else passes++;
    cpu_we = 1'b0;
    tick();
  endtask

  task automatic test_full_wrap();
    cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h0000_3333;
    for (int i = 0; i < DEPTH; i++) begin
      drive_io(1'b1, 5'(10 + i), 32'hF000_0000 + 32'(i), 1'b1);
      tick();
    end
    checks++;
    if ({io_ready, io_pending} !== {1'b0, OCC_W'(DEPTH)})
      $display("FAIL full_flags: ready=%0b pending=%0d want 0/%0d", io_ready, io_pending, DEPTH);
    else passes++;
    drive_io(1'b1, 5'd20, 32'h0000_0BAD, 1'b0);
    tick();
    drive_io(1'b0, 5'd0, 32'd0, 1'b0);
    cpu_we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {(e[36:32] != 5'd0), e})
        $display("FAIL full_order_%0d: got addr=%0d data=%h want addr=%0d data=%h", i, rf_waddr, rf_wdata, e[36:32], e[31:0]);
      else passes++;
      tick();
    end
    #1;
    checks++;
    if ({io_pending, rf_we} !== {OCC_W'(0), 1'b0})
      $display("FAIL full_no_fifth: pending=%0d we=%0b want 0/0", io_pending, rf_we);
    else passes++;
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) drive_io(1'b1, 5'(16 + i), 32'hC000_0000 + 32'(i), 1'b1);
      else drive_io(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      if (i > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {(e[36:32] != 5'd0), e})
          $display("FAIL wrap_order_%0d: got addr=%0d data=%h want addr=%0d data=%h", i, rf_waddr, rf_wdata, e[36:32], e[31:0]);
        else passes++;
      end
      if (i == 3) begin
        checks++;
        if (io_pending !== OCC_W'(1)) $display("FAIL wrap_pending: got %0d want 1", io_pending);
        else passes++;
      end
      tick();
    end
    checks++;
    if (io_pending !== OCC_W'(0)) $display("FAIL wrap_drained: got %0d want 0", io_pending);
    else passes++;
  endtask

  task automatic test_r0();
    cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h0000_3333;
    drive_io(1'b1, 5'd0, 32'h0000_1111, 1'b1);
    tick();
    drive_io(1'b1, 5'd9, 32'h0000_9999, 1'b1);
    tick();
    drive_io(1'b0, 5'd0, 32'd0, 1'b0);
    cpu_waddr = 5'd0; cpu_wdata = 32'h0000_EEEE;
    #1;
    checks++;
    if (io_pending !== OCC_W'(2)) $display("FAIL r0_pending: got %0d want 2", io_pending);
    else passes++;
    e = exp_q.pop_front();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {(e[36:32] != 5'd0), e})
      $display("FAIL r0_head: got we=%0b addr=%0d data=%h want we=0 addr=0 data=%h", rf_we, rf_waddr, rf_wdata, e[31:0]);
    else passes++;
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {(e[36:32] != 5'd0), e})
      $display("FAIL r0_next: got we=%0b addr=%0d data=%h want 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e[36:32], e[31:0]);
    else passes++;
    tick();
    checks++;
    if ({io_pending, r0_written} !== {OCC_W'(0), 1'b0})
      $display("FAIL r0_protect: pending=%0d r0_written=%0b want 0/0", io_pending, r0_written);
    else passes++;
    cpu_we = 1'b0;
  endtask

  task automatic test_simul_same_addr();
    cpu_we = 1'b1; cpu_waddr = 5'd4; cpu_wdata = 32'hC0C0_C0C0;
    drive_io(1'b1, 5'd4, 32'h1010_1010, 1'b1);
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hC0C0_C0C0})
      $display("FAIL same_addr_cpu: got we=%0b addr=%0d data=%h want 1/4/c0c0c0c0", rf_we, rf_waddr, rf_wdata);
    else passes++;
    tick();
    cpu_waddr = 5'd5; cpu_wdata = 32'h0000_5555;
    drive_io(1'b1, 5'd6, 32'h0000_6666, 1'b1);
    tick();
    cpu_we = 1'b0;
    drive_io(1'b1, 5'd7, 32'h0000_7777, 1'b1);
    #1;
    checks++;
    if (io_pending !== OCC_W'(2)) $display("FAIL simul_pre: got %0d want 2", io_pending);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata} !== {(e[36:32] != 5'd0), e})
        $display("FAIL simul_issue_%0d: got addr=%0d data=%h want addr=%0d data=%h", i, rf_waddr, rf_wdata, e[36:32], e[31:0]);
      else passes++;
      tick();
      drive_io(1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      if (i == 0) begin
        checks++;
        if (io_pending !== OCC_W'(2)) $display("FAIL simul_post: got %0d want 2", io_pending);
        else passes++;
      end
    end
    checks++;
    if ({io_pending, shadow[4]} !== {OCC_W'(0), 32'h1010_1010})
      $display("FAIL same_addr_final: pending=%0d r4=%h want 0/10101010", io_pending, shadow[4]);
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    cpu_we = 1'b1; cpu_waddr = 5'd3; cpu_wdata = 32'h0000_3333;
    drive_io(1'b1, 5'd14, 32'h0000_1414, 1'b1);
    tick();
    drive_io(1'b0, 5'd0, 32'd0, 1'b0);
    repeat (STARVE_LIMIT) tick();
    checks++;
    if (stall_cpu !== 1'b1) $display("FAIL mid_stall_pre: got %0b want 1", stall_cpu);
    else passes++;
    ctrl_reset = 1'b0;
    #1;
    checks++;
    if ({stall_cpu, io_pending, rf_we, io_ready} !== {1'b0, OCC_W'(0), 1'b0, 1'b1})
      $display("FAIL mid_stall_reset: stall=%0b pending=%0d we=%0b ready=%0b want 0/0/0/1", stall_cpu, io_pending, rf_we, io_ready);
    else passes++;
    exp_q.delete();
    tick();
    ctrl_reset = 1'b1;
    cpu_we = 1'b0;
    #1;
    checks++;
    if ({io_pending, rf_we, stall_cpu} !== {OCC_W'(0), 1'b0, 1'b0})
      $display("FAIL mid_stall_after: pending=%0d we=%0b stall=%0b want 0/0/0", io_pending, rf_we, stall_cpu);
    else passes++;
    tick();
  endtask

  initial begin
    ctrl_reset = 1'b0;
    cpu_we = 1'b0; cpu_waddr = 5'd0; cpu_wdata = 32'd0;
    io_valid = 1'b0; io_waddr = 5'd0; io_wdata = 32'd0;
    test_reset();
    test_idle_issue();
    test_starvation();
    test_full_wrap();
    test_r0();
    test_simul_same_addr();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
